// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg
// Shared definitions for the reg_alu program sequencer:
//   - buffer geometry (DEPTH, AW, IW)
//   - instruction word field layout and a packed view of it
//   - reg_alu opcode constants
//   - sequencer FSM state encoding
//   - run-length clamp helper
package reg_alu_pkg;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int IW    = 29;

   // Instruction field positions
   localparam int SEL_BIT    = 28;
   localparam int WR_BIT     = 27;
   localparam int OP_MSB     = 26;
   localparam int OP_LSB     = 25;
   localparam int RDA_MSB    = 24;
   localparam int RDA_LSB    = 22;
   localparam int RDB_MSB    = 21;
   localparam int RDB_LSB    = 19;
   localparam int WADDR_MSB  = 18;
   localparam int WADDR_LSB  = 16;
   localparam int DIN_MSB    = 15;
   localparam int DIN_LSB    = 0;

   // reg_alu opcodes
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } seq_state_e;

   // Packed view matching the field positions above, MSB first
   typedef struct packed {
      logic        sel;
      logic        wr;
      logic [1:0]  op;
      logic [2:0]  rd_a;
      logic [2:0]  rd_b;
      logic [2:0]  wr_addr;
      logic [15:0] d_in;
   } instr_t;

   // Requested run lengths above the buffer depth run the whole buffer
   function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
      if (l > (AW+1)'(DEPTH)) begin
         clamp_len = (AW+1)'(DEPTH);
      end else begin
         clamp_len = l;
      end
   endfunction

endpackage

// File: rtl/reg_alu_prog_mem.sv
// reg_alu_prog_mem
// Instruction buffer: DEPTH x IW register array, one synchronous write
// port and one combinational read port. Cleared to zero by reset.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   i_we/i_waddr/i_wdata   write port
//   i_raddr/o_rdata        combinational read port
module reg_alu_prog_mem #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int IW    = 29
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [IW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [IW-1:0] o_rdata
);

   logic [IW-1:0] r_mem [DEPTH];

   // Storage array write, cleared on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/reg_alu_seq.sv
// reg_alu_seq
// Program sequencer driving the reg_alu control port from an 8-entry
// instruction buffer. One instruction is issued per clock while busy;
// read data and carry are captured per instruction into res_*.
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   prog_we/prog_addr/prog_data  buffer load (ignored while running)
//   start, len                   run request and run length (clamped)
//   busy, done                   run status
//   sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in   reg_alu control
//   d_out_a, d_out_b, cout       reg_alu results
//   res_a, res_b, res_cout, res_valid   captured results
//   carry_cnt                    carries from ALU-sourced instructions
module reg_alu_seq
   import reg_alu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic          start,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          sel,
   output logic          wr,
   output logic [1:0]    op,
   output logic [2:0]    rd_addr_a,
   output logic [2:0]    rd_addr_b,
   output logic [2:0]    wr_addr,
   output logic [15:0]   d_in,
   input  logic [15:0]   d_out_a,
   input  logic [15:0]   d_out_b,
   input  logic          cout,
   output logic [15:0]   res_a,
   output logic [15:0]   res_b,
   output logic          res_cout,
   output logic          res_valid,
   output logic [AW:0]   carry_cnt
);

   seq_state_e    r_state;
   seq_state_e    w_state_nxt;
   logic [AW-1:0] r_pc;
   logic [AW:0]   r_len;
   logic [AW-1:0] w_rd_addr;
   logic          w_load;
   logic          w_start_ok;
   logic          w_last;
   logic          w_mem_we;
   logic [IW-1:0] w_rdata;
   instr_t        w_instr;

   assign w_start_ok = (r_state == ST_IDLE) && start && (len != '0);
   // r_pc indexes the instruction currently on the control outputs
   assign w_last     = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));
   // The buffer is frozen during a run
   assign w_mem_we   = prog_we && (r_state != ST_RUN);
   assign w_instr    = instr_t'(w_rdata);

   reg_alu_prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .IW    (IW)
   ) u_prog_mem (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_mem_we),
      .i_waddr (prog_addr),
      .i_wdata (prog_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, plus which buffer word (if any) is issued at the next edge
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_rd_addr   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ok) begin
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_load    = 1'b1;
               w_rd_addr = r_pc + AW'(1);
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Program counter, run length and carry counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc      <= '0;
         r_len     <= '0;
         carry_cnt <= '0;
      end else if (w_start_ok) begin
         r_pc      <= '0;
         r_len     <= clamp_len(len);
         carry_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         if (!w_last) begin
            r_pc <= r_pc + AW'(1);
         end
         // sel here is the instruction being closed by this edge
         if (sel && cout) begin
            carry_cnt <= carry_cnt + (AW+1)'(1);
         end
      end
   end

   // Registered status and control outputs; control is zero when not issuing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         sel       <= 1'b0;
         wr        <= 1'b0;
         op        <= 2'b00;
         rd_addr_a <= 3'd0;
         rd_addr_b <= 3'd0;
         wr_addr   <= 3'd0;
         d_in      <= 16'h0000;
      end else begin
         busy <= (w_state_nxt == ST_RUN);
         done <= (w_state_nxt == ST_DONE);
         if (w_load) begin
            sel       <= w_instr.sel;
            wr        <= w_instr.wr;
            op        <= w_instr.op;
            rd_addr_a <= w_instr.rd_a;
            rd_addr_b <= w_instr.rd_b;
            wr_addr   <= w_instr.wr_addr;
            d_in      <= w_instr.d_in;
         end else begin
            sel       <= 1'b0;
            wr        <= 1'b0;
            op        <= 2'b00;
            rd_addr_a <= 3'd0;
            rd_addr_b <= 3'd0;
            wr_addr   <= 3'd0;
            d_in      <= 16'h0000;
         end
      end
   end

   // Result capture at the edge closing each issued instruction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_a     <= 16'h0000;
         res_b     <= 16'h0000;
         res_cout  <= 1'b0;
         res_valid <= 1'b0;
      end else if (r_state == ST_RUN) begin
         res_a     <= d_out_a;
         res_b     <= d_out_b;
         res_cout  <= cout;
         res_valid <= 1'b1;
      end else begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq
// Self-checking bench: a behavioural reg_alu register file answers the
// sequencer's control port, and a program-level reference model predicts
// every per-cycle status, issued control word, result and carry count.
module tb_reg_alu_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        prog_we;
   logic [2:0]  prog_addr;
   logic [28:0] prog_data;
   logic        start;
   logic [3:0]  len;
   logic        busy, done, sel, wr;
   logic [1:0]  op;
   logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
   logic [15:0] d_in, d_out_a, d_out_b, res_a, res_b;
   logic        cout, res_cout, res_valid;
   logic [3:0]  carry_cnt;
   logic [15:0] alu_y;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   reg_alu_seq dut (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .len(len), .busy(busy),
      .done(done), .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a),
      .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in),
      .d_out_a(d_out_a), .d_out_b(d_out_b), .cout(cout), .res_a(res_a),
      .res_b(res_b), .res_cout(res_cout), .res_valid(res_valid),
      .carry_cnt(carry_cnt)
   );

   // reg_alu arithmetic: returns {carry, result}
   function automatic logic [16:0] alu_fn(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
      case (o)
         2'b00:   return {1'b0, a} + {1'b0, b};
         2'b01:   return {(a < b), a - b};
         2'b10:   return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   // Behavioural reg_alu slave
   logic [15:0] alu_regs [8] = '{default: 16'h0000};
   always_comb begin
      d_out_a = alu_regs[rd_addr_a];
      d_out_b = alu_regs[rd_addr_b];
      {cout, alu_y} = alu_fn(op, d_out_a, d_out_b);
   end
   always @(posedge clk) begin
      if (wr) alu_regs[wr_addr] <= sel ? alu_y : d_in;
   end

   // Reference state
   logic [28:0] prog [8];
   logic [15:0] ref_regs [8] = '{default: 16'h0000};
   logic [32:0] exp_res [8];
   int          exp_carry;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [28:0] mk(input logic s, input logic w, input logic [1:0] o,
                                      input logic [2:0] ra, input logic [2:0] rb,
                                      input logic [2:0] wa, input logic [15:0] d);
      return {s, w, o, ra, rb, wa, d};
   endfunction

   function automatic logic [28:0] ctrl_word();
      return {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in};
   endfunction

   // Execute the first n program words on the reference register file
   task automatic model_run(input int n);
      logic [16:0] r;
      logic [28:0] w;
      exp_carry = 0;
      for (int i = 0; i < n; i++) begin
         w = prog[i];
         r = alu_fn(w[26:25], ref_regs[w[24:22]], ref_regs[w[21:19]]);
         exp_res[i] = {r[16], ref_regs[w[24:22]], ref_regs[w[21:19]]};
         if (w[28] && r[16]) exp_carry++;
         if (w[27]) ref_regs[w[18:16]] = w[28] ? r[15:0] : w[15:0];
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < 8; i++) begin
         prog_we = 1'b1; prog_addr = 3'(i); prog_data = prog[i];
         @(posedge clk); #1;
      end
      prog_we = 1'b0;
   endtask

   task automatic run_prog(input logic [3:0] l, input bit hold_start, input bit we_during);
      int n;
      n = (l > 4'd8) ? 8 : int'(l);
      model_run(n);
      len = l; start = 1'b1;
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      check("busy_e0", busy, 1);
      check("res_valid_e0", res_valid, 0);
      check("ctrl_0", ctrl_word(), prog[0]);
      if (we_during) begin
         prog_we = 1'b1; prog_addr = 3'($urandom()); prog_data = 29'($urandom());
      end
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (k == n) begin
            prog_we = 1'b0; start = 1'b0;
         end else if (we_during) begin
            prog_addr = 3'($urandom()); prog_data = 29'($urandom());
         end
         check("busy", busy, (k < n));
         check("done", done, (k == n));
         check("res_valid", res_valid, 1);
         check("res", {res_cout, res_a, res_b}, exp_res[k-1]);
         if (k < n) check("ctrl", ctrl_word(), prog[k]);
         else       check("ctrl_idle", ctrl_word(), 0);
      end
      @(posedge clk); #1;
      check("done_end", done, 0);
      check("busy_end", busy, 0);
      check("res_valid_end", res_valid, 0);
      check("carry_cnt", carry_cnt, exp_carry);
   endtask

   initial begin
      reset = 1'b0; prog_we = 1'b0; prog_addr = 3'd0; prog_data = 29'd0;
      start = 1'b0; len = 4'd0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ctrl", ctrl_word(), 0);
      check("rst_res", {res_valid, res_cout, res_a, res_b}, 0);
      check("rst_carry", carry_cnt, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Immediate writes then read back
      for (int i = 0; i < 8; i++) prog[i] = 29'd0;
      prog[0] = mk(1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 3'd3, 16'hcdef);
      prog[1] = mk(1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 3'd7, 16'h3210);
      prog[2] = mk(1'b0, 1'b0, 2'b00, 3'd3, 3'd7, 3'd0, 16'h0000);
      load_prog();
      run_prog(4'd3, 1'b0, 1'b0);
      check("t1_res_a", res_a, 16'hcdef);
      check("t1_res_b", res_b, 16'h3210);

      // ALU write-back
      prog[2] = mk(1'b1, 1'b1, 2'b00, 3'd3, 3'd7, 3'd5, 16'h0000);
      prog[3] = mk(1'b0, 1'b0, 2'b00, 3'd5, 3'd0, 3'd0, 16'h0000);
      load_prog();
      run_prog(4'd4, 1'b0, 1'b0);
      check("t2_res_a", res_a, 16'hffff);
      check("t2_carry", carry_cnt, 0);

      // Carry
      prog[0] = mk(1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 3'd1, 16'h8000);
      prog[1] = mk(1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 3'd2, 16'h8000);
      prog[2] = mk(1'b1, 1'b1, 2'b00, 3'd1, 3'd2, 3'd4, 16'h0000);
      load_prog();
      run_prog(4'd3, 1'b0, 1'b0);
      check("t3_res_a", res_a, 16'h8000);
      check("t3_res_cout", res_cout, 1);
      check("t3_carry", carry_cnt, 1);
      @(posedge clk); #1;
      check("t3_carry_hold", carry_cnt, 1);
      prog[0] = mk(1'b0, 1'b0, 2'b00, 3'd4, 3'd4, 3'd0, 16'h0000);
      load_prog();
      run_prog(4'd1, 1'b0, 1'b0);
      check("t3_r4", res_a, 16'h0000);

      // len = 0 is ignored
      len = 4'd0; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("len0_busy", busy, 0);
         check("len0_done", done, 0);
      end
      start = 1'b0;

      // Clamp, start held while busy, writes during run ignored
      for (int i = 0; i < 8; i++) prog[i] = 29'($urandom());
      load_prog();
      run_prog(4'd15, 1'b1, 1'b1);
      run_prog(4'd8, 1'b0, 1'b0);

      // Randomized programs and lengths
      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < 8; i++) prog[i] = 29'($urandom());
            load_prog();
         end
         run_prog(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset mid-run
      for (int i = 0; i < 8; i++) prog[i] = 29'($urandom());
      load_prog();
      model_run(2);
      len = 4'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("mr_busy", busy, 0);
      check("mr_done", done, 0);
      check("mr_ctrl", ctrl_word(), 0);
      check("mr_res", {res_valid, res_cout, res_a, res_b}, 0);
      check("mr_carry", carry_cnt, 0);
      @(posedge clk); #1;
      check("mr_done_hold", done, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) prog[i] = 29'd0;
      run_prog(4'd6, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
